maq_h: RTL and testbench
========================

// Module: maq_h
// PURPOSE
//  Hours stage of the digital clock. Consumes the hour-carry produced by the minutes
//  stage and keeps hours as two BCD digits, in 24 h or 12 h+AM/PM format.
//  Also takes a manual set input and emits a one-cycle day-carry pulse on midnight
//  rollover for a future date stage.
// PARAMETERS
//  FORMATO_24H   1  1: display 00..23; 0: display 12,01..11 with maqh_pm flag
//  HORA_INICIAL  0  reset hour, 24 h binary 0..23 (>23 = elaboration error)
// PORTS
//  maqh_clock           in   1  system clock, all state on rising edge
//  maqh_reset           in   1  asynchronous, active-low reset
//  maqh_enable          in   1  count enable; when 0, digits hold
//  maqh_incremento      in   1  hour carry from minutes stage (level, rising edge counted)
//  maqh_ajuste          in   1  manual hour-set request (level, rising edge counted)
//  maqh_Lsd             out  4  hour units, BCD 0..9
//  maqh_Msd             out  2  hour tens, BCD 0..2
//  maqh_pm              out  1  12 h mode: 1 = PM; forced 0 in 24 h mode
//  maqh_incrementadia   out  1  one-cycle pulse on midnight rollover from carry
// BEHAVIOUR
//  Reset (maqh_reset=0, immediate, async):
//  - digits = HORA_INICIAL in the selected format; maqh_pm per HORA_INICIAL (>=12)
//    in 12 h mode.
//  - maqh_incrementadia = 0; both edge-detect registers = 0.
//  Edge detection:
//  - ev_inc = maqh_incremento & ~inc_q; ev_aj = maqh_ajuste & ~aj_q.
//  - inc_q/aj_q register the inputs every cycle, regardless of enable.
//  - A held-high input counts exactly once.
//  Step (cycle after edge, only if maqh_enable=1 and (ev_inc | ev_aj)):
//  - Exactly one hour advance per cycle, even if both events coincide.
//  - Edges arriving while enable=0 are discarded, not queued.
//  24 h sequence:
//  - Lsd 9 -> 0 and Msd+1.
//  - 23 -> 00 (Msd=2 & Lsd=3 wraps both digits to 0).
//  12 h sequence (digits 12,01,02..11, then 12):
//  - 09 -> 10; 11 -> 12 toggles maqh_pm; 12 -> 01 leaves maqh_pm unchanged.
//  Day carry:
//  - maqh_incrementadia = 1 for exactly one cycle, registered with the digit update.
//  - 24 h: set when 23->00 is caused by ev_inc.
//  - 12 h: set when 11 PM -> 12 AM is caused by ev_inc.
//  - A wrap caused only by ev_aj never pulses (manual set does not advance the date).
//  - ev_inc & ev_aj together at wrap -> single advance, pulse asserted.
//  - Default 0 every other cycle.
//  Invariants:
//  - Outputs never show an invalid code (Lsd>9, Msd>2, 24..29, or 00/13+ in 12 h mode).
//  - Reset mid-step overrides everything, including a pending pulse.
// TESTING
//  T1 24h, HORA_INICIAL=23, enable=1: single ev_inc -> Msd/Lsd=0/0,
//     maqh_incrementadia high exactly 1 cycle.
//  T2 24h, from 09: ev_inc -> 10; hold maqh_incremento high 5 cycles -> still 10.
//  T3 12h, HORA_INICIAL=23 (11 PM): ev_inc -> 12, pm=0, incrementadia pulse;
//     next ev_inc -> 01, pm=0.
//  T4 24h at 23: ev_aj only -> 00, incrementadia stays 0;
//     ev_aj+ev_inc same cycle from 22 -> 23 (one step).
//  T5 enable=0, pulse maqh_incremento twice -> digits unchanged;
//     enable=1 afterward with input low -> still unchanged.
//  T6 assert maqh_reset low mid-count between clock edges -> outputs = HORA_INICIAL
//     immediately, no pulse; 24 ev_inc after release -> back to start value, 1 pulse.

Source files
------------

// File: rtl/maq_h.sv
// Hours stage of the digital clock: BCD hour digits in 24 h or 12 h+AM/PM
// format, advanced by carry or manual set, with a midnight day-carry pulse.
module maq_h #(
  parameter int FORMATO_24H  = 1,
  parameter int HORA_INICIAL = 0
) (
  input  logic       maqh_clock,
  input  logic       maqh_reset,
  input  logic       maqh_enable,
  input  logic       maqh_incremento,
  input  logic       maqh_ajuste,
  output logic [3:0] maqh_Lsd,
  output logic [1:0] maqh_Msd,
  output logic       maqh_pm,
  output logic       maqh_incrementadia
);

  generate
    if (HORA_INICIAL < 0 || HORA_INICIAL > 23) begin : g_bad_init
      $error("maq_h: HORA_INICIAL must be 0..23");
    end
  endgenerate

  localparam logic [4:0] INI = 5'(HORA_INICIAL);

  logic [4:0] hora;
  logic       inc_q;
  logic       aj_q;
  logic       dia_q;
  logic       ev_inc;
  logic       ev_aj;
  logic       ultima;

  assign ev_inc = maqh_incremento & ~inc_q;
  assign ev_aj  = maqh_ajuste & ~aj_q;
  assign ultima = (hora == 5'd23);

  // hour is kept as 24 h binary; display format is derived below
  always_ff @(posedge maqh_clock or negedge maqh_reset) begin
    if (!maqh_reset) begin
      hora  <= INI;
      inc_q <= 1'b0;
      aj_q  <= 1'b0;
      dia_q <= 1'b0;
    end else begin
      inc_q <= maqh_incremento;
      aj_q  <= maqh_ajuste;
      dia_q <= 1'b0;
      if (maqh_enable && (ev_inc || ev_aj)) begin
        hora  <= ultima ? 5'd0 : hora + 5'd1;
        dia_q <= ev_inc & ultima;
      end
    end
  end

  logic [4:0] h_disp;
  logic [4:0] unid;
  logic       pm_c;

  always_comb begin
    h_disp = hora;
    pm_c   = 1'b0;
    if (FORMATO_24H == 0) begin
      pm_c = (hora >= 5'd12);
      if (pm_c) begin
        h_disp = hora - 5'd12;
      end
      if (h_disp == 5'd0) begin
        h_disp = 5'd12;
      end
    end
  end

  always_comb begin
    maqh_Msd = 2'd0;
    unid     = h_disp;
    if (h_disp >= 5'd20) begin
      maqh_Msd = 2'd2;
      unid     = h_disp - 5'd20;
    end else if (h_disp >= 5'd10) begin
      maqh_Msd = 2'd1;
      unid     = h_disp - 5'd10;
    end
  end

  assign maqh_Lsd           = unid[3:0];
  assign maqh_pm            = pm_c;
  assign maqh_incrementadia = dia_q;

endmodule

// File: tb/tb_maq_h.sv
// Bench for maq_h: a 24 h and a 12 h instance share stimulus and are
// compared every cycle against an hour-count model plus literal checks.
module tb_maq_h;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic inc = 1'b0;
  logic aj  = 1'b0;

  logic [3:0] l24, l12;
  logic [1:0] m24, m12;
  logic       p24, p12;
  logic       d24, d12;

  int total  = 0;
  int passed = 0;
  int pulses24 = 0;
  int pulses12 = 0;

  always #5 clk = ~clk;

  maq_h #(.FORMATO_24H(1), .HORA_INICIAL(23)) u24 (
    .maqh_clock(clk), .maqh_reset(rst),
    .maqh_enable(en), .maqh_incremento(inc),
    .maqh_ajuste(aj), .maqh_Lsd(l24),
    .maqh_Msd(m24), .maqh_pm(p24),
    .maqh_incrementadia(d24)
  );

  maq_h #(.FORMATO_24H(0), .HORA_INICIAL(23)) u12 (
    .maqh_clock(clk), .maqh_reset(rst),
    .maqh_enable(en), .maqh_incremento(inc),
    .maqh_ajuste(aj), .maqh_Lsd(l12),
    .maqh_Msd(m12), .maqh_pm(p12),
    .maqh_incrementadia(d12)
  );

  // model: hour of day 0..23 and day-carry flag
  int mh    = 23;
  bit mdia  = 0;
  bit mincq = 0;
  bit majq  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mh    <= 23;
      mdia  <= 0;
      mincq <= 0;
      majq  <= 0;
    end else begin
      mincq <= inc;
      majq  <= aj;
      mdia  <= 0;
      if (en && ((inc && !mincq) || (aj && !majq))) begin
        mh   <= (mh + 1) % 24;
        mdia <= (inc && !mincq) && (mh == 23);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  int h12;
  always @(negedge clk) begin
    h12 = (mh % 12 == 0) ? 12 : mh % 12;
    chk("m24", int'(m24), mh / 10);
    chk("l24", int'(l24), mh % 10);
    chk("p24", int'(p24), 0);
    chk("d24", int'(d24), int'(mdia));
    chk("m12", int'(m12), h12 / 10);
    chk("l12", int'(l12), h12 % 10);
    chk("p12", int'(p12), int'(mh >= 12));
    chk("d12", int'(d12), int'(mdia));
    if (rst) begin
      pulses24 += int'(d24);
      pulses12 += int'(d12);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_aj(input int n);
    for (int i = 0; i < n; i++) begin
      aj = 1'b1; tick();
      aj = 1'b0; tick();
    end
  endtask

  task automatic lit24(input string nm, input int h,
                       input int dia);
    chk({nm, "_msd24"}, int'(m24), h / 10);
    chk({nm, "_lsd24"}, int'(l24), h % 10);
    chk({nm, "_dia24"}, int'(d24), dia);
  endtask

  task automatic lit12(input string nm, input int h,
                       input int pm, input int dia);
    chk({nm, "_msd12"}, int'(m12), h / 10);
    chk({nm, "_lsd12"}, int'(l12), h % 10);
    chk({nm, "_pm12"}, int'(p12), pm);
    chk({nm, "_dia12"}, int'(d12), dia);
  endtask

  initial begin
    #2 rst = 1'b0;
    tick();
    lit24("rst", 23, 0);
    lit12("rst", 11, 1, 0);
    tick();
    rst = 1'b1;
    tick();
    // T1/T3: carry wraps midnight, one-cycle pulse
    inc = 1'b1; tick();
    lit24("t1", 0, 1);
    lit12("t3a", 12, 0, 1);
    inc = 1'b0; tick();
    lit24("t1b", 0, 0);
    inc = 1'b1; tick();
    lit12("t3b", 1, 0, 0);
    inc = 1'b0; tick();
    // T2: 09 -> 10, held input counts once
    pulse_aj(8);
    lit24("t2a", 9, 0);
    inc = 1'b1;
    repeat (5) tick();
    inc = 1'b0; tick();
    lit24("t2b", 10, 0);
    lit12("t2c", 10, 0, 0);
    // T4: coincident events, manual wrap without pulse
    pulse_aj(12);
    inc = 1'b1; aj = 1'b1; tick();
    lit24("t4a", 23, 0);
    lit12("t4a", 11, 1, 0);
    inc = 1'b0; aj = 1'b0; tick();
    aj = 1'b1; tick();
    lit24("t4b", 0, 0);
    lit12("t4b", 12, 0, 0);
    aj = 1'b0; tick();
    pulse_aj(23);
    inc = 1'b1; aj = 1'b1; tick();
    lit24("t4c", 0, 1);
    inc = 1'b0; aj = 1'b0; tick();
    // T5: edges while disabled are dropped
    en = 1'b0;
    repeat (2) begin
      inc = 1'b1; tick();
      inc = 1'b0; tick();
    end
    inc = 1'b1; tick();
    en = 1'b1;
    repeat (2) tick();
    inc = 1'b0; tick();
    lit24("t5", 0, 0);
    // T6: async reset kills a pending pulse
    pulse_aj(23);
    inc = 1'b1; tick();
    lit24("t6a", 0, 1);
    #2 rst = 1'b0; inc = 1'b0;
    #1;
    lit24("t6b", 23, 0);
    lit12("t6b", 11, 1, 0);
    tick();
    rst = 1'b1;
    tick();
    pulses24 = 0;
    pulses12 = 0;
    for (int i = 0; i < 24; i++) begin
      inc = 1'b1; tick();
      inc = 1'b0; tick();
    end
    tick();
    lit24("t6c", 23, 0);
    lit12("t6c", 11, 1, 0);
    chk("t6_pulses24", pulses24, 1);
    chk("t6_pulses12", pulses12, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
